csi_header_scheduler: RTL and testbench

Builds and sequences CSI-2 packet headers for the gearbox/DMA transmit path. It arbitrates between frame-start, frame-end and long-packet requesters and assembles the 24-bit header (VC/DT, WC or data field). It appends the 6-bit Hamming ECC, maintains the frame counter, and presents each 32-bit header on a valid/ready stream to the lane packer.

---
 rtl/csi_header_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_csi_header_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_header_scheduler.sv
// csi_header_scheduler
// Arbitrates frame-start / frame-end / long-packet header requests, builds the
// 24-bit CSI-2 packet header, appends the 6-bit Hamming ECC and presents the
// 32-bit header on a valid/ready stream. Keeps the frame counter.
// Optional feature macro: CSI_LINE_SYNC_EN adds line-start / line-end headers
// and the line counter.
module csi_header_scheduler #(
  parameter logic [1:0]  VC        = 2'd0,
  parameter logic [15:0] FRAME_MAX = 16'hFFFF,
  parameter int          DT_CHECK  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_req,
  output logic        fs_ack,
  input  logic        fe_req,
  output logic        fe_ack,
  input  logic        lp_req,
  input  logic [5:0]  lp_dt,
  input  logic [15:0] lp_wc,
  output logic        lp_ack,
  output logic [31:0] hdr_data,
  output logic        hdr_short,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [15:0] frame_num,
  output logic        dt_err,
`ifdef CSI_LINE_SYNC_EN
  input  logic        ls_req,
  output logic        ls_ack,
  input  logic        le_req,
  output logic        le_ack,
  output logic [15:0] line_num,
`endif
  output logic        busy
);

  localparam logic [15:0] FRAME_INIT = (FRAME_MAX == 16'd0) ? 16'd0 : 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_OUT} state_t;
  typedef enum logic [2:0] {K_FS, K_FE, K_LS, K_LE, K_LP} kind_t;

  state_t      r_state;
  state_t      w_next;
  kind_t       r_kind;
  kind_t       w_kind;
  logic        r_live;
  logic [7:0]  r_byte0;
  logic [15:0] r_field;
  logic        r_short;
  logic [31:0] r_hdr_data;
  logic        r_hdr_short;
  logic        r_hdr_valid;
  logic [15:0] r_frame_num;
  logic        w_load;
  logic [5:0]  w_dt;
  logic [15:0] w_field;
  logic        w_short;
  logic [23:0] w_d;
  logic [5:0]  w_ecc;
  logic        w_hs;
`ifdef CSI_LINE_SYNC_EN
  logic [15:0] r_line_num;
`endif

  // Grants stay off until the first clock after reset release, so a request
  // held through reset never produces an ack while reset is asserted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_live <= 1'b0;
    else         r_live <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state, fixed-priority grant, ack/dt_err pulses and header field selection.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_dt    = 6'd0;
    w_field = 16'd0;
    w_short = 1'b0;
    w_kind  = K_LP;
    fs_ack  = 1'b0;
    fe_ack  = 1'b0;
    lp_ack  = 1'b0;
    dt_err  = 1'b0;
`ifdef CSI_LINE_SYNC_EN
    ls_ack  = 1'b0;
    le_ack  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_live) begin
          if (fe_req) begin
            fe_ack = 1'b1; w_load = 1'b1; w_dt = 6'h01;
            w_field = r_frame_num; w_short = 1'b1; w_kind = K_FE;
          end else if (fs_req) begin
            fs_ack = 1'b1; w_load = 1'b1; w_dt = 6'h00;
            w_field = r_frame_num; w_short = 1'b1; w_kind = K_FS;
`ifdef CSI_LINE_SYNC_EN
          end else if (le_req) begin
            le_ack = 1'b1; w_load = 1'b1; w_dt = 6'h03;
            w_field = r_line_num; w_short = 1'b1; w_kind = K_LE;
          end else if (ls_req) begin
            ls_ack = 1'b1; w_load = 1'b1; w_dt = 6'h02;
            w_field = r_line_num; w_short = 1'b1; w_kind = K_LS;
`endif
          end else if (lp_req) begin
            lp_ack = 1'b1;
            if ((DT_CHECK != 0) && (lp_dt < 6'h10)) begin
              dt_err = 1'b1;
            end else begin
              w_load = 1'b1; w_dt = lp_dt;
              w_field = lp_wc; w_short = 1'b0; w_kind = K_LP;
            end
          end
        end
        if (w_load) w_next = S_BUILD;
      end
      S_BUILD: w_next = S_OUT;
      S_OUT:   if (hdr_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the granted header fields on the ack cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byte0 <= 8'd0;
      r_field <= 16'd0;
      r_short <= 1'b0;
      r_kind  <= K_LP;
    end else if (w_load) begin
      r_byte0 <= {VC, w_dt};
      r_field <= w_field;
      r_short <= w_short;
      r_kind  <= w_kind;
    end
  end

  assign w_d = {r_field, r_byte0};

  assign w_ecc[0] = w_d[0] ^ w_d[1] ^ w_d[2] ^ w_d[4] ^ w_d[5] ^ w_d[7] ^ w_d[10] ^ w_d[11] ^
                    w_d[13] ^ w_d[16] ^ w_d[20] ^ w_d[21] ^ w_d[22] ^ w_d[23];
  assign w_ecc[1] = w_d[0] ^ w_d[1] ^ w_d[3] ^ w_d[4] ^ w_d[6] ^ w_d[8] ^ w_d[10] ^ w_d[12] ^
                    w_d[14] ^ w_d[17] ^ w_d[20] ^ w_d[21] ^ w_d[22] ^ w_d[23];
  assign w_ecc[2] = w_d[0] ^ w_d[2] ^ w_d[3] ^ w_d[5] ^ w_d[6] ^ w_d[9] ^ w_d[11] ^ w_d[12] ^
                    w_d[15] ^ w_d[18] ^ w_d[20] ^ w_d[21] ^ w_d[22];
  assign w_ecc[3] = w_d[1] ^ w_d[2] ^ w_d[3] ^ w_d[7] ^ w_d[8] ^ w_d[9] ^ w_d[13] ^ w_d[14] ^
                    w_d[15] ^ w_d[19] ^ w_d[20] ^ w_d[21] ^ w_d[23];
  assign w_ecc[4] = w_d[4] ^ w_d[5] ^ w_d[6] ^ w_d[7] ^ w_d[8] ^ w_d[9] ^ w_d[16] ^ w_d[17] ^
                    w_d[18] ^ w_d[19] ^ w_d[20] ^ w_d[22] ^ w_d[23];
  assign w_ecc[5] = w_d[10] ^ w_d[11] ^ w_d[12] ^ w_d[13] ^ w_d[14] ^ w_d[15] ^ w_d[16] ^
                    w_d[17] ^ w_d[18] ^ w_d[19] ^ w_d[21] ^ w_d[22] ^ w_d[23];

  assign w_hs = r_hdr_valid && hdr_ready;

  // Register the finished header in BUILD and hold it until the stream handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hdr_data  <= 32'd0;
      r_hdr_short <= 1'b0;
      r_hdr_valid <= 1'b0;
    end else if (r_state == S_BUILD) begin
      r_hdr_data  <= {2'b00, w_ecc, w_d};
      r_hdr_short <= r_short;
      r_hdr_valid <= 1'b1;
    end else if (w_hs) begin
      r_hdr_valid <= 1'b0;
    end
  end

  // Frame counter advances when an FE header is accepted downstream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_num <= FRAME_INIT;
    end else if (w_hs && (r_kind == K_FE)) begin
      if (FRAME_MAX == 16'd0)           r_frame_num <= 16'd0;
      else if (r_frame_num >= FRAME_MAX) r_frame_num <= 16'd1;
      else                               r_frame_num <= r_frame_num + 16'd1;
    end
  end

`ifdef CSI_LINE_SYNC_EN
  // Line counter restarts on FS acceptance and advances on LE acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_line_num <= 16'd1;
    end else if (w_hs && (r_kind == K_FS)) begin
      r_line_num <= 16'd1;
    end else if (w_hs && (r_kind == K_LE)) begin
      if (r_line_num == 16'hFFFF) r_line_num <= 16'd1;
      else                        r_line_num <= r_line_num + 16'd1;
    end
  end

  assign line_num = r_line_num;
`endif

  assign hdr_data  = r_hdr_data;
  assign hdr_short = r_hdr_short;
  assign hdr_valid = r_hdr_valid;
  assign frame_num = r_frame_num;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_csi_header_scheduler.sv
// Self-checking bench for csi_header_scheduler.
// Two instances share all stimulus: A uses default parameters, B uses VC=1 and
// FRAME_MAX=2 so frame-number wrap is exercised alongside normal operation.
module tb_csi_header_scheduler;

  localparam int KFS = 0;
  localparam int KFE = 1;
  localparam int KLP = 2;

  // Column code of each header data bit in the CSI-2 24-bit Hamming code;
  // the ECC is the XOR of the codes of all set bits.
  localparam logic [5:0] ECC_CODE [0:23] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  logic        clk;
  logic        resetn;
  logic        fsReq, feReq, lpReq, hdrReady;
  logic [5:0]  lpDt;
  logic [15:0] lpWc;

  logic        aFsAck, aFeAck, aLpAck, aHdrShort, aHdrValid, aDtErr, aBusy;
  logic [31:0] aHdrData;
  logic [15:0] aFrameNum;
  logic        bFsAck, bFeAck, bLpAck, bHdrShort, bHdrValid, bDtErr, bBusy;
  logic [31:0] bHdrData;
  logic [15:0] bFrameNum;
`ifdef CSI_LINE_SYNC_EN
  logic        lsReq, leReq;
  logic        aLsAck, aLeAck, bLsAck, bLeAck;
  logic [15:0] aLineNum, bLineNum;
`endif

  int total = 0;
  int bad   = 0;
  int fnumA = 1;
  int fnumB = 1;

  csi_header_scheduler dutA (
    .clk(clk), .resetn(resetn),
    .fs_req(fsReq), .fs_ack(aFsAck), .fe_req(feReq), .fe_ack(aFeAck),
    .lp_req(lpReq), .lp_dt(lpDt), .lp_wc(lpWc), .lp_ack(aLpAck),
    .hdr_data(aHdrData), .hdr_short(aHdrShort), .hdr_valid(aHdrValid), .hdr_ready(hdrReady),
    .frame_num(aFrameNum), .dt_err(aDtErr),
`ifdef CSI_LINE_SYNC_EN
    .ls_req(lsReq), .ls_ack(aLsAck), .le_req(leReq), .le_ack(aLeAck), .line_num(aLineNum),
`endif
    .busy(aBusy));

  csi_header_scheduler #(.VC(2'd1), .FRAME_MAX(16'd2), .DT_CHECK(1)) dutB (
    .clk(clk), .resetn(resetn),
    .fs_req(fsReq), .fs_ack(bFsAck), .fe_req(feReq), .fe_ack(bFeAck),
    .lp_req(lpReq), .lp_dt(lpDt), .lp_wc(lpWc), .lp_ack(bLpAck),
    .hdr_data(bHdrData), .hdr_short(bHdrShort), .hdr_valid(bHdrValid), .hdr_ready(hdrReady),
    .frame_num(bFrameNum), .dt_err(bDtErr),
`ifdef CSI_LINE_SYNC_EN
    .ls_req(lsReq), .ls_ack(bLsAck), .le_req(leReq), .le_ack(bLeAck), .line_num(bLineNum),
`endif
    .busy(bBusy));

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Header word from its fields: byte0 {vc,dt}, field little-endian, ECC on top.
  function automatic logic [31:0] hdrWord(input logic [1:0] vc, input logic [5:0] dt,
                                          input logic [15:0] field);
    logic [23:0] d;
    logic [5:0]  ecc;
    d   = {field, vc, dt};
    ecc = 6'd0;
    for (int i = 0; i < 24; i++) if (d[i]) ecc = ecc ^ ECC_CODE[i];
    return {2'b00, ecc, d};
  endfunction

  // Frame numbers run 1..max then restart at 1; max of 0 pins them at 0.
  function automatic int nextFrame(input int cur, input int max);
    if (max == 0) return 0;
    return (cur % max) + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic fs, input logic lp,
                               input logic [5:0] dt, input logic [15:0] wc, input logic rdy);
    feReq    = fe;
    fsReq    = fs;
    lpReq    = lp;
    lpDt     = dt;
    lpWc     = wc;
    hdrReady = rdy;
  endtask

  // One full request: ack cycle, BUILD, OUT with optional stall, handshake.
  // keepFs raises fs_req from the ack cycle onward (together with FE, or as a
  // pending request that must wait for IDLE).
  task automatic runHeader(input int kind, input logic [5:0] dt, input logic [15:0] wc,
                           input int stall, input bit keepFs);
    logic [31:0] expA, expB;
    logic [3:0]  expAck;
    logic [5:0]  useDt;
    logic [15:0] fieldA, fieldB;
    bit          reject;
    reject = (kind == KLP) && (dt < 6'h10);
    @(negedge clk);
    applyStimulus(kind == KFE, (kind == KFS) || (keepFs && kind == KFE), kind == KLP, dt, wc, 1'b1);
    #1;
    expAck = {kind == KFE, kind == KFS, kind == KLP, reject};
    checkOutput("idle_busy", 32'(aBusy), 32'd0);
    checkOutput("idle_valid", 32'(aHdrValid), 32'd0);
    checkOutput("frame_num_a", 32'(aFrameNum), 32'(fnumA));
    checkOutput("frame_num_b", 32'(bFrameNum), 32'(fnumB));
    checkOutput("ack_a", 32'({aFeAck, aFsAck, aLpAck, aDtErr}), 32'(expAck));
    checkOutput("ack_b", 32'({bFeAck, bFsAck, bLpAck, bDtErr}), 32'(expAck));
    if (reject) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, dt, wc, 1'b1);
      #1;
      checkOutput("reject_valid", 32'(aHdrValid), 32'd0);
      checkOutput("reject_busy", 32'(aBusy), 32'd0);
      checkOutput("reject_ack", 32'({aFeAck, aFsAck, aLpAck, aDtErr}), 32'd0);
      return;
    end
    case (kind)
      KFS:     begin useDt = 6'h00; fieldA = 16'(fnumA); fieldB = 16'(fnumB); end
      KFE:     begin useDt = 6'h01; fieldA = 16'(fnumA); fieldB = 16'(fnumB); end
      default: begin useDt = dt;    fieldA = wc;         fieldB = wc;         end
    endcase
    expA = hdrWord(2'd0, useDt, fieldA);
    expB = hdrWord(2'd1, useDt, fieldB);
    @(negedge clk);
    applyStimulus(1'b0, keepFs, 1'b0, dt, wc, stall == 0);
    #1;
    checkOutput("build_valid", 32'(aHdrValid), 32'd0);
    checkOutput("build_busy", 32'(aBusy), 32'd1);
    checkOutput("build_ack", 32'({aFeAck, aFsAck, aLpAck, aDtErr}), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("out_valid", 32'(aHdrValid), 32'd1);
    checkOutput("out_data_a", aHdrData, expA);
    checkOutput("out_data_b", bHdrData, expB);
    checkOutput("out_short", 32'(aHdrShort), 32'(kind != KLP));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_valid", 32'(aHdrValid), 32'd1);
      checkOutput("stall_data", aHdrData, expA);
      checkOutput("stall_ack", 32'({aFeAck, aFsAck, aLpAck, aDtErr}), 32'd0);
    end
    hdrReady = 1'b1;
    if (kind == KFE) begin
      fnumA = nextFrame(fnumA, 16'hFFFF);
      fnumB = nextFrame(fnumB, 2);
    end
  endtask

  initial begin
    int kind;
    logic [5:0]  rdt;
    logic [15:0] rwc;
`ifdef CSI_LINE_SYNC_EN
    lsReq = 1'b0;
    leReq = 1'b0;
`endif
    // Reset with a request already pending: nothing may be acknowledged.
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 16'd0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ack", 32'({aFeAck, aFsAck, aLpAck, aDtErr}), 32'd0);
    checkOutput("rst_valid", 32'(aHdrValid), 32'd0);
    checkOutput("rst_data", aHdrData, 32'd0);
    checkOutput("rst_short", 32'(aHdrShort), 32'd0);
    checkOutput("rst_frame", 32'(aFrameNum), 32'd1);
    checkOutput("rst_busy", 32'(aBusy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] basic FS / FE / LP headers");
    runHeader(KFS, 6'd0, 16'd0, 0, 1'b0);
    runHeader(KFE, 6'd0, 16'd0, 0, 1'b0);
    runHeader(KLP, 6'h2B, 16'h0500, 0, 1'b0);

    $display("[TB] downstream stall with pending FS");
    runHeader(KLP, 6'h2B, 16'h0500, 5, 1'b1);
    runHeader(KFS, 6'd0, 16'd0, 0, 1'b0);
    runHeader(KFE, 6'd0, 16'd0, 0, 1'b0);

    $display("[TB] rejected long-packet data type");
    runHeader(KLP, 6'h05, 16'h1234, 0, 1'b0);
    runHeader(KLP, 6'h0F, 16'h0001, 0, 1'b0);

    $display("[TB] reset during BUILD");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 16'd0, 1'b1);
    #1;
    checkOutput("rb_ack", 32'(aFsAck), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1);
    #1;
    checkOutput("rb_busy", 32'(aBusy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rb_valid", 32'(aHdrValid), 32'd0);
    checkOutput("rb_frame", 32'(aFrameNum), 32'd1);
    checkOutput("rb_state", 32'(aBusy), 32'd0);
    fnumA = 1;
    fnumB = 1;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("rb_discard", 32'(aHdrValid), 32'd0);
    end

    $display("[TB] simultaneous FE and FS at frame 1");
    runHeader(KFE, 6'd0, 16'd0, 0, 1'b1);
    runHeader(KFS, 6'd0, 16'd0, 0, 1'b0);

    $display("[TB] three frames for wrap check");
    for (int f = 0; f < 3; f++) begin
      runHeader(KFS, 6'd0, 16'd0, f, 1'b0);
      runHeader(KLP, 6'h2A, 16'(f * 3 + 1), 0, 1'b0);
      runHeader(KFE, 6'd0, 16'd0, 0, 1'b0);
    end

    $display("[TB] zero word count");
    runHeader(KLP, 6'h3F, 16'h0000, 1, 1'b0);

    $display("[TB] reset during OUT");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h24, 16'hABCD, 1'b0);
    #1;
    checkOutput("ro_ack", 32'(aLpAck), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("ro_valid_before", 32'(aHdrValid), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("ro_valid_after", 32'(aHdrValid), 32'd0);
    checkOutput("ro_data_after", aHdrData, 32'd0);
    fnumA = 1;
    fnumB = 1;
    @(negedge clk);
    hdrReady = 1'b1;
    resetn = 1'b1;

    $display("[TB] randomized requests");
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      rdt  = 6'($urandom_range(0, 63));
      rwc  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      runHeader(kind, rdt, rwc, int'($urandom_range(0, 3)), 1'b0);
    end

    @(negedge clk);
    #1;
    checkOutput("final_frame_a", 32'(aFrameNum), 32'(fnumA));
    checkOutput("final_frame_b", 32'(bFrameNum), 32'(fnumB));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
